// File: rtl/reorder_buffer_if.sv
// Reorder-buffer bus: global enable, issue, write-back, operand query and commit/rollback.
// master = decoder/execution side, slave = reorder_buffer.
interface reorder_buffer_if #(
    parameter int unsigned ROB_POS_W = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned REG_POS_W = 5
);
    logic                 rdy;

    logic                 issue;
    logic [REG_POS_W-1:0] issue_rd;
    logic                 issue_is_br;
    logic                 issue_pred_jump;
    logic [DATA_W-1:0]    issue_alt_pc;
    logic [ROB_POS_W-1:0] issue_rob_pos;
    logic                 full;

    logic                 alu_wb;
    logic [ROB_POS_W-1:0] alu_wb_pos;
    logic [DATA_W-1:0]    alu_wb_val;
    logic                 alu_wb_jump;

    logic                 lsb_wb;
    logic [ROB_POS_W-1:0] lsb_wb_pos;
    logic [DATA_W-1:0]    lsb_wb_val;

    logic [ROB_POS_W-1:0] qry1_pos;
    logic [ROB_POS_W-1:0] qry2_pos;
    logic                 qry1_ready;
    logic [DATA_W-1:0]    qry1_val;
    logic                 qry2_ready;
    logic [DATA_W-1:0]    qry2_val;

    logic                 commit;
    logic [REG_POS_W-1:0] commit_rd;
    logic [DATA_W-1:0]    commit_val;
    logic [ROB_POS_W-1:0] commit_rob_pos;
    logic                 rollback;
    logic [DATA_W-1:0]    rollback_pc;

    modport master (
        output rdy, issue, issue_rd, issue_is_br, issue_pred_jump, issue_alt_pc,
        output alu_wb, alu_wb_pos, alu_wb_val, alu_wb_jump,
        output lsb_wb, lsb_wb_pos, lsb_wb_val, qry1_pos, qry2_pos,
        input  issue_rob_pos, full, qry1_ready, qry1_val, qry2_ready, qry2_val,
        input  commit, commit_rd, commit_val, commit_rob_pos, rollback, rollback_pc
    );

    modport slave (
        input  rdy, issue, issue_rd, issue_is_br, issue_pred_jump, issue_alt_pc,
        input  alu_wb, alu_wb_pos, alu_wb_val, alu_wb_jump,
        input  lsb_wb, lsb_wb_pos, lsb_wb_val, qry1_pos, qry2_pos,
        output issue_rob_pos, full, qry1_ready, qry1_val, qry2_ready, qry2_val,
        output commit, commit_rd, commit_val, commit_rob_pos, rollback, rollback_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement queue for the RV32I OoO core; commits one entry per cycle, flushes on mispredict.
// Optional: define ROB_WB_BYPASS_EN to retire the head in the same cycle its write-back arrives.
module reorder_buffer #(
    parameter int unsigned ROB_SIZE  = 16,
    parameter int unsigned ROB_POS_W = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned REG_POS_W = 5
) (
    input logic             clk,
    input logic             rst_n,
    reorder_buffer_if.slave bus
);
    logic [ROB_SIZE-1:0]  busy, ready, is_br, pred, jump;
    logic [REG_POS_W-1:0] rd     [ROB_SIZE];
    logic [DATA_W-1:0]    val    [ROB_SIZE];
    logic [DATA_W-1:0]    alt_pc [ROB_SIZE];

    logic [ROB_POS_W-1:0] head, tail;
    logic [ROB_POS_W:0]   count;

    logic              do_issue, alu_ok, lsb_ok;
    logic              retire, mispredict;
    logic [DATA_W-1:0] ret_val;
    logic              ret_jump;

    always_comb begin
        bus.full          = (count == (ROB_POS_W+1)'(ROB_SIZE));
        bus.issue_rob_pos = tail;
        // Inputs presented during the flush cycle belong to the squashed window.
        do_issue = bus.issue && !bus.full && !bus.rollback;
        alu_ok   = bus.alu_wb && !bus.rollback && busy[bus.alu_wb_pos];
        lsb_ok   = bus.lsb_wb && !bus.rollback && busy[bus.lsb_wb_pos];

        retire   = busy[head] && ready[head];
        ret_val  = val[head];
        ret_jump = jump[head];
`ifdef ROB_WB_BYPASS_EN
        if (busy[head] && !ready[head]) begin
            if (alu_ok && bus.alu_wb_pos == head) begin
                retire   = 1'b1;
                ret_val  = bus.alu_wb_val;
                ret_jump = bus.alu_wb_jump;
            end else if (lsb_ok && bus.lsb_wb_pos == head) begin
                retire  = 1'b1;
                ret_val = bus.lsb_wb_val;
            end
        end
`endif
        mispredict = retire && is_br[head] && (ret_jump != pred[head]);
    end

    function automatic logic [DATA_W:0] lookup(input logic [ROB_POS_W-1:0] pos);
        if (ready[pos])
            return {1'b1, val[pos]};
        if (bus.alu_wb && bus.alu_wb_pos == pos)
            return {1'b1, bus.alu_wb_val};
        if (bus.lsb_wb && bus.lsb_wb_pos == pos)
            return {1'b1, bus.lsb_wb_val};
        return '0;
    endfunction

    always_comb begin
        {bus.qry1_ready, bus.qry1_val} = lookup(bus.qry1_pos);
        {bus.qry2_ready, bus.qry2_val} = lookup(bus.qry2_pos);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= '0;
            ready <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (bus.rdy) begin
            if (mispredict) begin
                busy  <= '0;
                ready <= '0;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (do_issue) begin
                    busy[tail]  <= 1'b1;
                    ready[tail] <= 1'b0;
                    tail        <= tail + 1'b1;
                end
                if (alu_ok)
                    ready[bus.alu_wb_pos] <= 1'b1;
                if (lsb_ok)
                    ready[bus.lsb_wb_pos] <= 1'b1;
                // Retire clear is last so it overrides a write-back landing on the head.
                if (retire) begin
                    busy[head]  <= 1'b0;
                    ready[head] <= 1'b0;
                    head        <= head + 1'b1;
                end
                unique case ({do_issue, retire})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Payload fields need no reset: busy/ready gate every use.
    always_ff @(posedge clk) begin
        if (bus.rdy) begin
            if (do_issue) begin
                rd[tail]     <= bus.issue_rd;
                is_br[tail]  <= bus.issue_is_br;
                pred[tail]   <= bus.issue_pred_jump;
                jump[tail]   <= bus.issue_pred_jump;
                alt_pc[tail] <= bus.issue_alt_pc;
            end
            if (alu_ok) begin
                val[bus.alu_wb_pos]  <= bus.alu_wb_val;
                jump[bus.alu_wb_pos] <= bus.alu_wb_jump;
            end
            if (lsb_ok)
                val[bus.lsb_wb_pos] <= bus.lsb_wb_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.commit         <= 1'b0;
            bus.commit_rd      <= '0;
            bus.commit_val     <= '0;
            bus.commit_rob_pos <= '0;
            bus.rollback       <= 1'b0;
            bus.rollback_pc    <= '0;
        end else if (bus.rdy) begin
            bus.commit   <= retire;
            bus.rollback <= mispredict;
            if (retire) begin
                bus.commit_rd      <= is_br[head] ? '0 : rd[head];
                bus.commit_val     <= ret_val;
                bus.commit_rob_pos <= head;
            end
            if (mispredict)
                bus.rollback_pc <= alt_pc[head];
        end else begin
            bus.commit   <= 1'b0;
            bus.rollback <= 1'b0;
        end
    end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement queue for the RV32I out-of-order core. It allocates an entry per issued instruction and captures results from the ALU and load/store write-back ports. Entries retire strictly in program order, and retirement drives the register-file commit interface (`commit`, `commit_rd`, `commit_val`, `commit_rob_pos`). On a mispredicted branch at the head it flushes the whole window via `rollback`.

## Interface
- `ROB_SIZE`, 16: number of entries; must be a power of two.
- `ROB_POS_W`, 4: entry index width; equals log2(`ROB_SIZE`).
- `DATA_W`, 32: result width.
- `REG_POS_W`, 5: architectural register index width.
- `clk`  in  1  clock; every state change is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rdy`  in  1  global enable; when low, all state holds.
- `issue`  in  1  allocate the entry at `tail` this cycle.
- `issue_rd`  in  `REG_POS_W`  destination register; 0 means no register write.
- `issue_is_br`  in  1  entry is a conditional branch.
- `issue_pred_jump`  in  1  predicted branch direction.
- `issue_alt_pc`  in  `DATA_W`  PC to fetch from if the prediction proves wrong.
- `issue_rob_pos`  out  `ROB_POS_W`  current `tail`; combinational.
- `full`  out  1  asserted when `count == ROB_SIZE`; combinational from registered `count`.
- `alu_wb`, `alu_wb_pos`, `alu_wb_val`, `alu_wb_jump`  in  1/`ROB_POS_W`/`DATA_W`/1  ALU result write-back.
- `lsb_wb`, `lsb_wb_pos`, `lsb_wb_val`  in  1/`ROB_POS_W`/`DATA_W`  load/store result write-back.
- `qry1_pos`, `qry2_pos`  in  `ROB_POS_W`  operand lookups from the decoder.
- `qry1_ready`, `qry1_val`, `qry2_ready`, `qry2_val`  out  1/`DATA_W`  combinational lookup results.
- `commit`  out  1  registered pulse; one entry retired.
- `commit_rd`  out  `REG_POS_W`  destination of the retired entry.
- `commit_val`  out  `DATA_W`  result of the retired entry.
- `commit_rob_pos`  out  `ROB_POS_W`  index of the retired entry.
- `rollback`  out  1  registered pulse; flush the pipeline.
- `rollback_pc`  out  `DATA_W`  redirect target, valid while `rollback` is high.

## Operation
- Storage is a circular buffer with per-entry fields `busy`, `ready`, `rd`, `val`, `is_br`, `pred`, `jump`, `alt_pc`.
- Pointers `head` and `tail` wrap modulo `ROB_SIZE`; `count` is `ROB_POS_W+1` bits wide.
- Issue (`issue && !full`):
  - The entry at `tail` gets `busy=1`, `ready=0`, and the issued fields.
  - `tail` increments.
  - Issue while `full` is ignored.
- Write-back:
  - A write-back to a `busy` entry sets `ready=1` and stores `val`.
  - On the ALU port it also stores `jump`.
  - Write-back to a non-busy entry is ignored.
  - Both ports may write in the same cycle; a same-entry collision is illegal.
- Retire: when the head entry is `busy && ready`:
  - Next edge: `commit=1`, and `commit_rd/val/rob_pos` come from the head entry.
  - The entry is cleared, `head` increments, and `count` decrements.
  - At most one retire per cycle.
  - Branch entries retire with `commit_rd=0`.
- Mispredict: the retiring head is `is_br` with `jump != pred`.
  - Same edge: `commit=1` and `rollback=1`, with `rollback_pc = alt_pc`.
  - All `busy` bits clear; `head = tail = count = 0`.
- Flush cycle: while `rollback` is high, the decoder must not issue, and any `issue` or write-back presented in that cycle is discarded.
- Query: `qryN_ready=1` when any of these holds; otherwise `ready=0` and `val=0`:
  - the entry is `ready` — `val` is the stored value;
  - `alu_wb` targets `qryN_pos` this cycle — `val` is `alu_wb_val`;
  - `lsb_wb` targets `qryN_pos` this cycle — `val` is `lsb_wb_val`.
- Simultaneous issue and retire: `count` is unchanged, and both pointers advance.

## Timing
- Reset (`rst_n` low, asynchronous):
  - Outputs: `commit`, `commit_rd`, `commit_val`, `commit_rob_pos`, `rollback`, `rollback_pc` = 0.
  - State: `head`, `tail`, `count` = 0; all `busy` and `ready` = 0.
  - Status: `full` = 0, `issue_rob_pos` = 0.
  - Mid-operation reset discards every in-flight entry.
- `commit` and `rollback` are single-cycle pulses; they deassert on the next edge unless another retire occurs.
- `rdy=0`: no state changes; `commit` and `rollback` go to 0 at the next edge.
- Issue-to-retire minimum latency:
  - Write-back at edge N sets `ready`; `commit` goes high after edge N+1.
  - With `ROB_WB_BYPASS_EN`, `commit` goes high after edge N.
- Full boundary:
  - `full` is based on the registered `count`, so issue is refused even when a retire happens in the same cycle.
  - After that retire, `full` drops on the next cycle.
- Wrap-around: `tail` of 15 plus an issue gives 0; `head` behaves the same way.

## Configuration
- `ROB_WB_BYPASS_EN` defined:
  - Retire also fires when the head is `busy && !ready` and either write-back port targets `head` this cycle.
  - Retirement then uses the write-back value and jump bit.
  - This applies to the mispredict check as well.
- Not defined: retire requires the stored `ready=1`, giving one extra cycle of latency.

## Test plan
- Reset with 3 entries in flight → all outputs 0; `full=0`; `issue_rob_pos=0`.
- Issue rd=5 at pos 0, ALU write-back 0x1234 → one `commit` pulse with rd=5, val=0x1234, pos 0.
  - Timing: edge N+1 without bypass, edge N with bypass.
- Issue 16 entries → `full=1`, and a 17th issue is ignored.
  - Retire one → `full=0` next cycle.
  - The next issue lands at pos 0 after wrap.
- Write back pos 2 then pos 0, leaving pos 1 pending → pos 0 retires; pos 2 waits until pos 1 is written; commits arrive in order 0, 1, 2.
- Branch at head with pred=0, jump=1, alt_pc=0x100, three younger entries → `commit` and `rollback` together with `rollback_pc=0x100`.
  - Afterwards `count=0` and `issue_rob_pos=0`.
  - An `issue` presented during the rollback cycle is dropped.
- Query pos 3 in the same cycle as `lsb_wb` to pos 3 with 0xBEEF → `qry1_ready=1`, `qry1_val=0xBEEF`, combinationally.
